// File: rtl/hazard_controller.sv
// hazard_controller: pipeline interlock for load-use, taken branch and data-memory wait states,
// with a memory-timeout FSM and saturating stall/flush perf counters.
module hazard_controller #(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [4:0]       rs1D,
   input  logic [4:0]       rs2D,
   input  logic [4:0]       rdE,
   input  logic             ResultSrcE0,
   input  logic             PCSrcE,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   input  logic             ClrCounters,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             MemErr,
   output logic [CNT_W-1:0] StallCycles,
   output logic [CNT_W-1:0] FlushCount
);
   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
   state_t        state;
   logic [WW-1:0] wait_cnt;
   logic          mem_stall, lw_stall, hold, br, ld;
   always_comb begin
      mem_stall = MemReqM & ~MemReadyM;
      lw_stall  = ResultSrcE0 & (rdE != 5'd0) & ((rdE == rs1D) | (rdE == rs2D));
      // reset_n gates every term so all stall/flush outputs read 0 while in reset
      hold      = reset_n & (mem_stall | (state == ERR));
      br        = reset_n & ~hold & PCSrcE;
      ld        = reset_n & ~hold & ~PCSrcE & lw_stall;
   end
   assign StallF = hold | ld;
   assign StallD = hold | ld;
   assign StallE = hold;
   assign StallM = hold;
   assign FlushD = br;
   assign FlushE = br | ld;
   assign FlushW = hold;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= RUN;
         wait_cnt <= '0;
         MemErr   <= 1'b0;
      end else begin
         case (state)
            RUN: if (mem_stall) begin
               state    <= MEM_WAIT;
               wait_cnt <= WW'(1);
            end
            MEM_WAIT: if (MemReadyM || !MemReqM) begin
               state    <= RUN;
               wait_cnt <= '0;
            end else if (wait_cnt == WW'(MEM_TIMEOUT)) begin
               state  <= ERR;
               MemErr <= 1'b1;
            end else begin
               wait_cnt <= wait_cnt + WW'(1);
            end
            ERR: MemErr <= 1'b1;
            default: state <= RUN;
         endcase
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         StallCycles <= '0;
         FlushCount  <= '0;
      end else if (ClrCounters) begin
         StallCycles <= '0;
         FlushCount  <= '0;
      end else begin
         if ((StallF | StallD | StallE | StallM) && !(&StallCycles)) StallCycles <= StallCycles + CNT_W'(1);
         if (br && !(&FlushCount)) FlushCount <= FlushCount + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: scoreboard bench; a spec-level model pushes expected results when
// stimulus is driven, and they are popped and compared when the DUT produces them.
module tb_hazard_controller;
   localparam int CW = 4;
   localparam int TO = 4;
   localparam int SAT = (1 << CW) - 1;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [4:0] rs1D = '0, rs2D = '0, rdE = '0;
   logic ResultSrcE0 = 1'b0, PCSrcE = 1'b0, MemReqM = 1'b0, MemReadyM = 1'b0, ClrCounters = 1'b0;
   logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
   logic [CW-1:0] StallCycles, FlushCount;
   logic [6:0] ctrl;
   typedef struct {logic [6:0] ctrl; logic err; int sc; int fc;} exp_t;
   exp_t exp_q[$];
   int n_chk = 0, n_pass = 0;
   int m_state = 0, m_cnt = 0, m_sc = 0, m_fc = 0;
   logic m_err = 1'b0;
   hazard_controller #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n), .rs1D(rs1D), .rs2D(rs2D), .rdE(rdE),
      .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .ClrCounters(ClrCounters), .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr),
      .StallCycles(StallCycles), .FlushCount(FlushCount)
   );
   assign ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   // one clock of stimulus, called at a negedge; returns at the next negedge
   task automatic cyc(input string tag, input logic ld, input logic [4:0] rd, r1, r2,
                      input logic pc, rq, rdy, clr);
      logic ms, lw, hold, br, lws;
      exp_t e;
      ResultSrcE0 = ld; rdE = rd; rs1D = r1; rs2D = r2;
      PCSrcE = pc; MemReqM = rq; MemReadyM = rdy; ClrCounters = clr;
      ms   = rq & ~rdy;
      lw   = ld && rd != 5'd0 && (rd == r1 || rd == r2);
      hold = ms || m_state == 2;
      br   = !hold && pc;
      lws  = !hold && !pc && lw;
      e.ctrl = {hold | lws, hold | lws, hold, hold, br, br | lws, hold};
      if (clr) begin
         m_sc = 0; m_fc = 0;
      end else begin
         if ((hold || lws) && m_sc < SAT) m_sc++;
         if (br && m_fc < SAT) m_fc++;
      end
      case (m_state)
         0: if (ms) begin m_state = 1; m_cnt = 1; end
         1: if (rdy || !rq) begin m_state = 0; m_cnt = 0; end
            else if (m_cnt == TO) begin m_state = 2; m_err = 1'b1; end
            else m_cnt++;
         default: m_state = 2;
      endcase
      e.err = m_err; e.sc = m_sc; e.fc = m_fc;
      exp_q.push_back(e);
      #1 chk({tag, "_ctrl"}, 32'(ctrl), 32'(exp_q[0].ctrl));
      @(posedge clk);
      #1 e = exp_q.pop_front();
      chk({tag, "_err"}, 32'(MemErr), 32'(e.err));
      chk({tag, "_sc"}, 32'(StallCycles), 32'(e.sc));
      chk({tag, "_fc"}, 32'(FlushCount), 32'(e.fc));
      @(negedge clk);
   endtask
   task automatic idle(input string tag);
      cyc(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask
   initial begin
      #2;
      chk("rst_ctrl", 32'(ctrl), 32'd0);
      chk("rst_err", 32'(MemErr), 32'd0);
      chk("rst_sc", 32'(StallCycles), 32'd0);
      chk("rst_fc", 32'(FlushCount), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      // load-use on rs1, then a bubble
      cyc("t1_lw", 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t1_sc_one", 32'(StallCycles), 32'd1);
      cyc("t1_bubble", 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("t1_rs2", 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("t1_nomatch", 1'b1, 5'd7, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("t1_notload", 1'b0, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
      // x0 destination never interlocks
      cyc("t2_x0", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      // branch beats load-use
      cyc("t3_br_lw", 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("t3_fc_one", 32'(FlushCount), 32'd1);
      cyc("t4_clr", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      // three wait states, with a masked branch + load-use in the middle one
      cyc("t4_w1", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("t4_w2", 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("t4_w3", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("t4_rdy", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("t4_sc_three", 32'(StallCycles), 32'd3);
      chk("t4_fc_masked", 32'(FlushCount), 32'd0);
      // request dropped mid-wait returns to RUN
      cyc("pv_w", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("pv_drop", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("pv_run", 1'b1, 5'd3, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
      // flush counter saturation
      for (int i = 0; i < 18; i++) cyc("fc_sat", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("fc_sat_held", 32'(FlushCount), 32'(SAT));
      cyc("t6_clr", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      // stuck memory: timeout into ERR, stall counter saturates
      for (int i = 0; i < 20; i++) begin
         cyc("t5_stuck", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
         if (i == 3) chk("t5_not_yet", 32'(MemErr), 32'd0);
         if (i == 4) chk("t5_err", 32'(MemErr), 32'd1);
      end
      chk("t6_sc_sat", 32'(StallCycles), 32'(SAT));
      // ERR holds the stall with the request gone and a branch pending
      cyc("t5_err_hold", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("t5_err_stall", 32'(ctrl), 32'h79);
      cyc("t6_clr_stall", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("t6_clr_zero", 32'(StallCycles), 32'd0);
      cyc("t6_after_clr", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      // asynchronous reset in the middle of ERR, with a memory stall still on the inputs
      MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
      #2 reset_n = 1'b0;
      m_state = 0; m_cnt = 0; m_err = 1'b0; m_sc = 0; m_fc = 0;
      #1;
      chk("t5_rst_ctrl", 32'(ctrl), 32'd0);
      chk("t5_rst_err", 32'(MemErr), 32'd0);
      chk("t5_rst_sc", 32'(StallCycles), 32'd0);
      chk("t5_rst_fc", 32'(FlushCount), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      idle("t5_after_rst");
      cyc("t5_after_lw", 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
